// File: rtl/elev_pkg.sv
// Shared floor types, FSM state encodings and floor-selection helpers
// for elevator_scheduler.
package elev_pkg;
    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W    = 2;

    typedef logic [FLOOR_W-1:0]    floor_t;
    typedef logic [NUM_FLOORS-1:0] floor_mask_t;
    typedef logic [1:0]            state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_MOVE_UP   = 2'd1;
    localparam state_t ST_MOVE_DOWN = 2'd2;
    localparam state_t ST_DOOR      = 2'd3;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic floor_mask_t above_mask(input floor_t cur);
        floor_mask_t m;
        m = '0;
        for (int f = 0; f < NUM_FLOORS; f++)
            if (f > int'(cur)) m[f] = 1'b1;
        return m;
    endfunction

    function automatic floor_mask_t below_mask(input floor_t cur);
        floor_mask_t m;
        m = '0;
        for (int f = 0; f < NUM_FLOORS; f++)
            if (f < int'(cur)) m[f] = 1'b1;
        return m;
    endfunction

    function automatic floor_t lowest_floor(input floor_mask_t m);
        floor_t r;
        r = '0;
        for (int f = NUM_FLOORS - 1; f >= 0; f--)
            if (m[f]) r = floor_t'(f);
        return r;
    endfunction

    function automatic floor_t highest_floor(input floor_mask_t m);
        floor_t r;
        r = '0;
        for (int f = 0; f < NUM_FLOORS; f++)
            if (m[f]) r = floor_t'(f);
        return r;
    endfunction

    // Scanning upward with a strict '<' makes the lower floor win a distance tie.
    function automatic floor_t nearest_floor(input floor_mask_t m, input floor_t cur);
        floor_t r;
        int     best;
        int     d;
        r    = '0;
        best = NUM_FLOORS;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            d = (f > int'(cur)) ? f - int'(cur) : int'(cur) - f;
            if (m[f] && d < best) begin
                best = d;
                r    = floor_t'(f);
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/door_timer.sv
// Door dwell timer: load to TICKS, decrement on enabled ticks, flag the last tick.
module door_timer #(
    parameter int unsigned TICKS = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic done
);
    logic [3:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= 4'(TICKS);
        else if (dec && count != 4'd0)
            count <= count - 4'd1;
    end

    assign done = (count == 4'd1);
endmodule

// File: rtl/elevator_scheduler.sv
// Four-floor elevator call scheduler (IDLE / MOVE_UP / MOVE_DOWN / DOOR).
// Optional auto-park to floor 0 when built with ELEV_SCHED_PARK_EN.
module elevator_scheduler
    import elev_pkg::*;
#(
    parameter int unsigned DOOR_TICKS = 3,
    parameter int unsigned PARK_TICKS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       stop,
    input  logic [3:0] call_req,
    input  logic [1:0] cur_floor,
    output logic [1:0] target_floor,
    output logic       target_valid,
    output logic       dir_up,
    output logic       dir_down,
    output logic       door_open,
    output logic [3:0] pending,
    output logic [3:0] served_count
);
    state_t      state, state_nx, sel_state;
    floor_t      target_nx, sel_target, near;
    logic        last_dir, last_dir_nx, sel_dir;
    logic        advance, here, reload, enter_door, timer_done;
    floor_mask_t pend_above, pend_below, call_mask, clr_mask;

    assign advance    = tick & ~stop;
    assign here       = pending[cur_floor];
    assign pend_above = pending & above_mask(cur_floor);
    assign pend_below = pending & below_mask(cur_floor);
    assign reload     = (state == ST_DOOR) && !stop && call_req[cur_floor];
    assign enter_door = (state != ST_DOOR) && (state_nx == ST_DOOR);

`ifdef ELEV_SCHED_PARK_EN
    localparam logic [7:0] PARK_LAST = 8'(PARK_TICKS - 1);
    logic [7:0] park_cnt;
    logic       parking, parking_nx, park_due;

    assign park_due = (state == ST_IDLE) && (pending == '0) && (cur_floor != '0)
                      && (park_cnt == PARK_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            park_cnt <= '0;
            parking  <= 1'b0;
        end else begin
            parking <= parking_nx;
            if (advance)
                park_cnt <= (state == ST_IDLE && pending == '0 && cur_floor != '0 && !park_due)
                            ? park_cnt + 8'd1 : '0;
        end
    end
`else
    logic [7:0] unused_park_ticks;
    assign unused_park_ticks = 8'(PARK_TICKS);
`endif

    // Plan from the idle position; also reused when a park run is aborted.
    always_comb begin
        sel_state  = ST_IDLE;
        sel_target = target_floor;
        sel_dir    = last_dir;
        near       = nearest_floor(pending, cur_floor);
        if (here) begin
            sel_state = ST_DOOR;
        end else if (pending != '0) begin
            sel_target = near;
            sel_state  = (near > cur_floor) ? ST_MOVE_UP : ST_MOVE_DOWN;
            sel_dir    = (near > cur_floor) ? DIR_UP : DIR_DOWN;
        end
    end

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx    = state;
        target_nx   = target_floor;
        last_dir_nx = last_dir;
`ifdef ELEV_SCHED_PARK_EN
        parking_nx  = parking;
`endif
        if (advance) begin
            case (state)
                ST_IDLE: begin
                    state_nx    = sel_state;
                    target_nx   = sel_target;
                    last_dir_nx = sel_dir;
`ifdef ELEV_SCHED_PARK_EN
                    if (park_due) begin
                        state_nx    = ST_MOVE_DOWN;
                        target_nx   = '0;
                        last_dir_nx = DIR_DOWN;
                        parking_nx  = 1'b1;
                    end
`endif
                end
                ST_MOVE_UP: begin
                    if (here)             state_nx  = ST_DOOR;
                    else if (|pend_above) target_nx = lowest_floor(pend_above);
                    else                  state_nx  = ST_IDLE;
                end
                ST_MOVE_DOWN: begin
                    if (here)             state_nx  = ST_DOOR;
                    else if (|pend_below) target_nx = highest_floor(pend_below);
                    else                  state_nx  = ST_IDLE;
`ifdef ELEV_SCHED_PARK_EN
                    if (parking) begin
                        state_nx    = sel_state;
                        target_nx   = sel_target;
                        last_dir_nx = sel_dir;
                        parking_nx  = 1'b0;
                        if (pending == '0 && cur_floor != '0) begin
                            state_nx    = ST_MOVE_DOWN;
                            target_nx   = '0;
                            last_dir_nx = DIR_DOWN;
                            parking_nx  = 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    if (timer_done && !reload) begin
                        if (|pend_above && last_dir == DIR_UP) begin
                            state_nx  = ST_MOVE_UP;
                            target_nx = lowest_floor(pend_above);
                        end else if (|pend_below && last_dir == DIR_DOWN) begin
                            state_nx  = ST_MOVE_DOWN;
                            target_nx = highest_floor(pend_below);
                        end else if (|pend_above) begin
                            state_nx    = ST_MOVE_UP;
                            target_nx   = lowest_floor(pend_above);
                            last_dir_nx = DIR_UP;
                        end else if (|pend_below) begin
                            state_nx    = ST_MOVE_DOWN;
                            target_nx   = highest_floor(pend_below);
                            last_dir_nx = DIR_DOWN;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // A call for the floor being served while the door is open only extends the dwell.
    always_comb begin
        call_mask = call_req;
        if (state == ST_DOOR) call_mask[cur_floor] = 1'b0;
        clr_mask = '0;
        if (enter_door) clr_mask[cur_floor] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            pending      <= '0;
            target_floor <= '0;
            served_count <= '0;
            last_dir     <= DIR_UP;
        end else begin
            state        <= state_nx;
            target_floor <= target_nx;
            last_dir     <= last_dir_nx;
            pending      <= (pending | call_mask) & ~clr_mask;
            if (enter_door) served_count <= served_count + 4'd1;
        end
    end

    door_timer #(.TICKS(DOOR_TICKS)) u_door_timer (
        .clock (clock),
        .reset (reset),
        .load  (enter_door | reload),
        .dec   (advance && state == ST_DOOR),
        .done  (timer_done)
    );

    assign dir_up       = (state == ST_MOVE_UP);
    assign dir_down     = (state == ST_MOVE_DOWN);
    assign door_open    = (state == ST_DOOR);
    assign target_valid = (dir_up | dir_down) & ~stop;
endmodule

// File: doc/elevator_scheduler.md
ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 Parameter DOOR_TICKS, default 3: ticks the door stays open per stop (1..15).
REQ-002 Parameter PARK_TICKS, default 8: idle ticks before parking; used only under ELEV_SCHED_PARK_EN (1..255).
REQ-003 clock  input  1  single clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tick  input  1  step enable from the clock divider; FSM and timers advance only when tick=1.
REQ-006 stop  input  1  emergency hold; freezes FSM and timers while high.
REQ-007 call_req  input  4  hall/cab call per floor, level-sampled every clock.
REQ-008 cur_floor  input  2  current floor reported by the elevator datapath.
REQ-009 target_floor  output  2  floor command to the elevator datapath.
REQ-010 target_valid  output  1  target_floor is a live command.
REQ-011 dir_up / dir_down  output  1 each  travel direction; never both 1.
REQ-012 door_open  output  1  high in DOOR state.
REQ-013 pending  output  4  latched outstanding calls.
REQ-014 served_count  output  4  stops served, wraps 15->0.

Function
REQ-015 FSM states IDLE, MOVE_UP, MOVE_DOWN, DOOR; transitions only on clock edges with tick=1 and stop=0.
REQ-016 pending[f] sets on any clock with call_req[f]=1, independent of tick/stop; clears only on DOOR entry at floor f.
REQ-017 Call for cur_floor while in DOOR: not latched; door timer reloads to DOOR_TICKS.
REQ-018 IDLE: pending[cur_floor]=1 -> DOOR; else nearest pending floor chosen, tie -> lower floor; target above -> MOVE_UP, below -> MOVE_DOWN; none -> stay.
REQ-019 MOVE_UP: target_floor = lowest pending floor above cur_floor; on pending[cur_floor]=1 -> DOOR.
REQ-020 MOVE_DOWN: target_floor = highest pending floor below cur_floor; on pending[cur_floor]=1 -> DOOR.
REQ-021 DOOR entry: clear pending[cur_floor], served_count+1, load timer DOOR_TICKS; timer decrements per tick; at 0 exit.
REQ-022 DOOR exit: pending above and last direction up -> MOVE_UP; pending below and last direction down -> MOVE_DOWN; else opposite side if pending; else IDLE.
REQ-023 target_valid=1 only in MOVE_UP/MOVE_DOWN with stop=0; dir_up/dir_down follow state; both 0 in IDLE/DOOR.
REQ-024 stop=1: target_valid=0, state/timers/target_floor held, door_open held; resume from same state when stop=0.
REQ-025 Calls latched in same cycle as a transition are visible to selection on the next tick.

Reset
REQ-026 reset=1 asynchronously forces IDLE, pending=0, target_floor=0, target_valid=0, dir=00, door_open=0, served_count=0, timers=0, last direction=up.
REQ-027 Reset mid-travel or mid-door discards all pending calls; no served_count increment.

Configuration
REQ-028 ELEV_SCHED_PARK_EN defined: after PARK_TICKS consecutive IDLE ticks with pending=0 and cur_floor!=0, enter MOVE_DOWN with target_floor=0; any new call aborts park and reselects per REQ-018; arrival at 0 -> IDLE without DOOR or served_count change.
REQ-029 ELEV_SCHED_PARK_EN undefined: no park logic; IDLE holds indefinitely; PARK_TICKS ignored.

Structure
REQ-030 Shared package elev_pkg holds state enum, NUM_FLOORS=4, FLOOR_W=2, direction encoding.
REQ-031 Sub-module door_timer (load/decrement/zero flag, tick-gated) is instantiated once; park counter stays inline.

Verification
REQ-032 Reset, cur_floor=0, call_req=0001 one clock, tick every cycle -> DOOR next tick, door_open 3 ticks, served_count=1, pending=0.
REQ-033 cur_floor=0, calls 1000 then 0100 -> MOVE_UP, target_floor=2 first, DOOR at 2, then target 3, served_count=2.
REQ-034 cur_floor=1 IDLE, calls 0001 and 0100 same clock -> tie, MOVE_DOWN to 0 first, then MOVE_UP to 2.
REQ-035 MOVE_UP with stop=1 for 5 ticks -> target_valid=0, state/timer frozen, call_req=0010 still latched in pending.
REQ-036 Park enabled, PARK_TICKS=8, cur_floor=2, no calls -> MOVE_DOWN target 0 after 8 ticks; disabled -> stays IDLE.
REQ-037 Assert reset during DOOR with pending=1010 -> all outputs to reset values immediately, served_count unchanged from 0.
